// File: rtl/maze_ctrl.sv
// maze_ctrl: sequences one maze job at a time. It resets and seeds an
// external maze generator, waits a bounded time for it to finish, and
// then streams the finished maze row by row over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        job request / cancel
//   seed_in             seed sampled when a start is accepted
//   gen_rst, gen_seed   generator reset and seed
//   gen_done            generator-complete flag
//   gen_row_idx/gen_row row select into the generator / selected row data
//   row_valid/row_ready streaming handshake
//   row_data/row_idx    streamed row and its index
//   row_last            streamed row is the final row
//   busy, err           job in progress / sticky generator timeout
//   maze_count          completed mazes, modulo 256
module maze_ctrl #(
  parameter int unsigned SIZE    = 9,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [15:0]     seed_in,
  output logic            gen_rst,
  output logic [15:0]     gen_seed,
  input  logic            gen_done,
  output logic [3:0]      gen_row_idx,
  input  logic [SIZE-1:0] gen_row,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [SIZE-1:0] row_data,
  output logic [3:0]      row_idx,
  output logic            row_last,
  output logic            busy,
  output logic            err,
  output logic [7:0]      maze_count
);

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [3:0]  LAST_IDX     = 4'(SIZE - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GEN_RST  = 2'd1,
    S_GEN_WAIT = 2'd2,
    S_STREAM   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_rst_cnt;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_gen_seed;
  logic        r_gen_rst;
  logic [3:0]  r_row_idx;
  logic        r_row_valid;
  logic        r_row_last;
  logic        r_busy;
  logic        r_err;
  logic [7:0]  r_maze_count;

  // Job sequencer; every output is updated together with the state so that
  // each one is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= 1'b0;
      r_wait_cnt   <= 16'd0;
      r_gen_seed   <= SEED_DEFAULT;
      r_gen_rst    <= 1'b1;
      r_row_idx    <= 4'd0;
      r_row_valid  <= 1'b0;
      r_row_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_maze_count <= 8'd0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Cancel: back to IDLE with count and err untouched.
      r_state     <= S_IDLE;
      r_gen_rst   <= 1'b1;
      r_row_idx   <= 4'd0;
      r_row_valid <= 1'b0;
      r_row_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_GEN_RST;
            r_err      <= 1'b0;
            // A zero seed would lock up the generator's LFSR.
            r_gen_seed <= (seed_in == 16'd0) ? SEED_DEFAULT : seed_in;
            r_rst_cnt  <= 1'b0;
            r_gen_rst  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_GEN_RST: begin
          if (r_rst_cnt) begin
            r_state    <= S_GEN_WAIT;
            r_gen_rst  <= 1'b0;
            r_wait_cnt <= 16'd0;
          end else begin
            r_rst_cnt <= 1'b1;
          end
        end
        S_GEN_WAIT: begin
          // gen_done takes priority over a timeout in the same cycle.
          if (gen_done) begin
            r_state     <= S_STREAM;
            r_row_idx   <= 4'd0;
            r_row_valid <= 1'b1;
            r_row_last  <= (LAST_IDX == 4'd0);
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state   <= S_IDLE;
            r_err     <= 1'b1;
            r_gen_rst <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_STREAM: begin
          if (row_ready) begin
            if (r_row_last) begin
              r_state      <= S_IDLE;
              r_maze_count <= r_maze_count + 8'd1;
              r_gen_rst    <= 1'b1;
              r_row_idx    <= 4'd0;
              r_row_valid  <= 1'b0;
              r_row_last   <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_row_idx  <= r_row_idx + 4'd1;
              r_row_last <= ((r_row_idx + 4'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // row_idx is held at zero outside STREAM, so it doubles as the row select.
  assign gen_row_idx = r_row_idx;
  assign row_data    = gen_row;
  assign gen_rst     = r_gen_rst;
  assign gen_seed    = r_gen_seed;
  assign row_valid   = r_row_valid;
  assign row_idx     = r_row_idx;
  assign row_last    = r_row_last;
  assign busy        = r_busy;
  assign err         = r_err;
  assign maze_count  = r_maze_count;

endmodule

// File: tb/tb_maze_ctrl.sv
module tb_maze_ctrl;

  localparam int SIZE = 9;

  logic clk;
  logic rst;

  // Main instance, default TIMEOUT
  logic            start, abort, gen_done, row_ready;
  logic [15:0]     seed_in;
  logic [SIZE-1:0] gen_row;
  wire             gen_rst, row_valid, row_last, busy, err;
  wire [15:0]      gen_seed;
  wire [3:0]       gen_row_idx, row_idx;
  wire [SIZE-1:0]  row_data;
  wire [7:0]       maze_count;

  // Second instance with a short timeout
  logic            start2, abort2, gen_done2, row_ready2;
  logic [15:0]     seed2;
  logic [SIZE-1:0] gen_row2;
  wire             gen_rst2, row_valid2, row_last2, busy2, err2;
  wire [15:0]      gen_seed2;
  wire [3:0]       gen_row_idx2, row_idx2;
  wire [SIZE-1:0]  row_data2;
  wire [7:0]       maze_count2;

  maze_ctrl #(.SIZE(SIZE), .TIMEOUT(4096)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_in(seed_in),
    .gen_rst(gen_rst), .gen_seed(gen_seed), .gen_done(gen_done),
    .gen_row_idx(gen_row_idx), .gen_row(gen_row),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .busy(busy), .err(err),
    .maze_count(maze_count)
  );

  maze_ctrl #(.SIZE(SIZE), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .seed_in(seed2),
    .gen_rst(gen_rst2), .gen_seed(gen_seed2), .gen_done(gen_done2),
    .gen_row_idx(gen_row_idx2), .gen_row(gen_row2),
    .row_valid(row_valid2), .row_ready(row_ready2), .row_data(row_data2),
    .row_idx(row_idx2), .row_last(row_last2), .busy(busy2), .err(err2),
    .maze_count(maze_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: maze memory plus a done flag that rises a fixed
  // number of cycles after its reset is released.
  logic [SIZE-1:0] maze_mem [16];
  assign gen_row = maze_mem[gen_row_idx];

  int   vectors    = 0;
  int   miscompares = 0;
  int   gcnt       = 0;
  int   gdelay     = 0;
  bit   force_done = 0;
  logic [7:0] exp_count = 8'd0;
  logic       exp_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; update generator model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_rst) gcnt = 0;
    else gcnt++;
    gen_done = force_done || (!gen_rst && (gcnt > gdelay));
  endtask

  // One complete job on the main instance.
  // mode: 1 ready always, 2 ready pattern 1,0,0,1, 3 random ready.
  task automatic run_job(input logic [15:0] seed, input int delay, input int mode,
                         input int abort_row, input bit start_w_abort, input bit extra_start);
    int k, c, hs, exp_idx;
    bit rdy;
    logic [15:0] exp_seed;
    gdelay = delay;
    for (int r = 0; r < SIZE; r++) maze_mem[r] = SIZE'($urandom);
    exp_seed = (seed == 16'd0) ? 16'hACE1 : seed;

    start = 1'b1; seed_in = seed; abort = start_w_abort;
    tick();
    start = 1'b0; abort = 1'b0; seed_in = 16'($urandom);
    exp_err = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_seed", gen_seed, exp_seed);
    check("accept_err", err, 0);
    check("gen_rst_cycle1", gen_rst, 1);
    tick();
    check("gen_rst_cycle2", gen_rst, 1);
    check("gen_rst_no_valid", row_valid, 0);
    tick();
    check("gen_rst_released", gen_rst, 0);
    check("wait_busy", busy, 1);

    k = 0;
    while (!row_valid && k < delay + 5) begin
      tick();
      k++;
    end
    check("gen_latency", k, delay + 1);
    if (!row_valid) return;

    exp_idx = 0; hs = 0; c = 0;
    while (exp_idx < SIZE && c < 16 * SIZE) begin
      case (mode)
        1: rdy = 1'b1;
        2: rdy = ((c % 4) == 0) || ((c % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      if (abort_row == exp_idx) begin
        abort = 1'b1; row_ready = rdy;
        tick();
        abort = 1'b0; row_ready = 1'b0;
        check("abort_valid", row_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count", maze_count, exp_count);
        check("abort_err", err, exp_err);
        check("abort_idx", row_idx, 0);
        return;
      end
      check("row_valid", row_valid, 1);
      check("row_idx", row_idx, exp_idx);
      check("row_data", row_data, maze_mem[exp_idx]);
      check("row_last", row_last, exp_idx == SIZE - 1);
      check("gen_row_idx", gen_row_idx, exp_idx);
      if (extra_start && c == 2) begin
        start = 1'b1; seed_in = ~exp_seed;
      end
      row_ready = rdy;
      tick();
      start = 1'b0; row_ready = 1'b0;
      if (extra_start && c == 2) check("ignored_start_seed", gen_seed, exp_seed);
      if (rdy) begin
        exp_idx++;
        hs++;
      end
      c++;
    end
    check("handshakes", hs, SIZE);
    if (mode == 1) check("stream_cycles", c, SIZE);
    exp_count = exp_count + 8'd1;
    check("done_valid", row_valid, 0);
    check("done_busy", busy, 0);
    check("done_count", maze_count, exp_count);
    check("done_gen_row_idx", gen_row_idx, 0);
    if (extra_start) begin
      tick();
      tick();
      check("no_second_job", busy, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, n;
    bit any_valid;
    for (int r = 0; r < 16; r++) maze_mem[r] = '0;
    rst = 1'b1; start = 0; abort = 0; seed_in = 0; gen_done = 0; row_ready = 0;
    start2 = 0; abort2 = 0; seed2 = 0; gen_done2 = 0; row_ready2 = 0; gen_row2 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_gen_rst", gen_rst, 1);
    check("rst_seed", gen_seed, 16'hACE1);
    check("rst_valid", row_valid, 0);
    check("rst_err", err, 0);
    check("rst_count", maze_count, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_gen_row_idx", gen_row_idx, 0);

    // Basic run
    run_job(16'h1234, 50, 1, -1, 0, 0);
    // Backpressure 1,0,0,1
    run_job(16'($urandom), 7, 2, -1, 0, 0);
    // Zero seed, start during STREAM ignored
    run_job(16'h0000, 3, 1, -1, 0, 1);
    // Abort at row 4
    run_job(16'($urandom), 5, 1, 4, 0, 0);
    // Start and abort together in IDLE: start wins
    run_job(16'($urandom), 2, 3, -1, 1, 0);
    // Abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_count", maze_count, exp_count);

    // Timeout on the short-timeout instance
    start2 = 1'b1; seed2 = 16'h0055;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    check("to_wait_entry", gen_rst2, 0);
    k = 0;
    while (busy2 && k < 40) begin
      tick();
      k++;
    end
    check("to_cycles", k, 16);
    check("to_err", err2, 1);
    check("to_gen_rst", gen_rst2, 1);
    check("to_valid", row_valid2, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("to_err_cleared", err2, 0);
    check("to_restart_busy", busy2, 1);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check("to_abort_gen_rst_busy", busy2, 0);
    check("to_abort_err", err2, 0);
    // gen_done on the timeout cycle wins
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_edge_still_busy", busy2, 1);
    gen_done2 = 1'b1;
    tick();
    gen_done2 = 1'b0;
    check("to_edge_stream", row_valid2, 1);
    check("to_edge_no_err", err2, 0);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check("to_edge_abort_valid", row_valid2, 0);
    check("to_edge_abort_count", maze_count2, 0);

    // Random jobs until maze_count wraps to zero
    n = 256 - int'(exp_count);
    for (int j = 0; j < n; j++)
      run_job(16'($urandom), int'($urandom_range(0, 6)), 3, -1, 0, 0);
    check("wrap_count", maze_count, 0);

    // Reset in the middle of GEN_WAIT
    start = 1'b1; seed_in = 16'hBEEF; gdelay = 1000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_count = 8'd0;
    check("async_busy", busy, 0);
    check("async_gen_rst", gen_rst, 1);
    check("async_seed", gen_seed, 16'hACE1);
    check("async_valid", row_valid, 0);
    check("async_err", err, 0);
    check("async_count", maze_count, 0);
    check("async_row_idx", row_idx, 0);
    tick();
    rst = 1'b0;
    force_done = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      row_ready = 1'b1;
      tick();
      any_valid = any_valid | row_valid;
    end
    row_ready = 1'b0;
    force_done = 1'b0;
    check("post_rst_no_valid", any_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_ctrl.md
MAZE_CTRL -- requirements
Module: maze_ctrl

Interface
REQ-001 Parameter SIZE, default 9: maze edge length in rows/columns, odd, 5..15.
REQ-002 Parameter TIMEOUT, default 4096: maximum GEN_WAIT cycles before error, 2..65535.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to generate and stream one maze.
REQ-006 abort  input  1  cancels an in-progress job.
REQ-007 seed_in  input  16  seed for the next job, sampled with an accepted start.
REQ-008 gen_rst  output  1  reset to the maze generator.
REQ-009 gen_seed  output  16  seed to the maze generator.
REQ-010 gen_done  input  1  generator-complete flag.
REQ-011 gen_row_idx  output  4  maze row currently selected from the generator.
REQ-012 gen_row  input  SIZE  maze row data at gen_row_idx; 1 = wall.
REQ-013 row_valid  output  1  row_data/row_idx/row_last are valid.
REQ-014 row_ready  input  1  consumer accepts the row.
REQ-015 row_data  output  SIZE  streamed maze row.
REQ-016 row_idx  output  4  index of the streamed row.
REQ-017 row_last  output  1  the streamed row is row SIZE-1.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.
REQ-019 err  output  1  sticky generator-timeout flag.
REQ-020 maze_count  output  8  count of fully streamed mazes, modulo 256.

Function
REQ-021 The FSM SHALL have the states IDLE, GEN_RST, GEN_WAIT and STREAM, and SHALL be encoded in 2 bits.
REQ-022 In IDLE, start=1 SHALL be accepted, SHALL clear err, SHALL latch gen_seed, and SHALL enter GEN_RST on the next edge.
REQ-023 On an accepted start, gen_seed SHALL load seed_in, or 16'hACE1 when seed_in=0, to avoid LFSR lock-up.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 GEN_RST SHALL hold gen_rst=1 for exactly 2 cycles and then enter GEN_WAIT.
REQ-026 gen_rst SHALL be 1 in IDLE and in GEN_RST, and 0 in GEN_WAIT and in STREAM.
REQ-027 GEN_WAIT SHALL count cycles from 0; gen_done=1 SHALL enter STREAM with row_idx=0.
REQ-028 If the GEN_WAIT count reaches TIMEOUT-1 with gen_done=0, the FSM SHALL set err=1 and return to IDLE.
REQ-029 If gen_done=1 on the same cycle as the timeout, gen_done SHALL win, with no err.
REQ-030 In STREAM, row_valid=1, gen_row_idx=row_idx, row_data=gen_row (combinational), and row_last=(row_idx==SIZE-1).
REQ-031 While row_valid=1 and row_ready=0, row_idx and row_data SHALL remain stable.
REQ-032 On row_valid and row_ready with row_last=0, row_idx SHALL increment.
REQ-033 On row_valid and row_ready with row_last=1, the FSM SHALL go to IDLE and maze_count SHALL increment, wrapping 255 to 0.
REQ-034 One row SHALL transfer per cycle maximum, so with row_ready held high a maze streams in SIZE cycles.
REQ-035 abort=1 in GEN_RST, GEN_WAIT or STREAM SHALL return the FSM to IDLE on the next edge.
REQ-036 An abort SHALL drop row_valid, SHALL leave maze_count unchanged and SHALL leave err unchanged.
REQ-037 abort in IDLE SHALL be ignored; start and abort together in IDLE SHALL accept the start.
REQ-038 Outside STREAM, row_valid=0 and gen_row_idx=0.
REQ-039 busy SHALL equal (state != IDLE).

Reset
REQ-040 rst=1 SHALL asynchronously force state=IDLE, gen_rst=1, gen_seed=16'hACE1, row_idx=0, row_valid=0, busy=0, err=0 and maze_count=0.
REQ-041 rst asserted mid-operation, in any state, SHALL abandon the job with no further row_valid after rst deasserts.
REQ-042 Outputs SHALL be stable from the first edge after rst deasserts.

Verification
REQ-043 Basic run: start with seed_in=16'h1234, model asserts gen_done 50 cycles later, row_ready=1 -> gen_rst high 2 cycles; 9 rows idx 0..8 on consecutive cycles; row_last on idx 8; maze_count=1; busy low after.
REQ-044 Backpressure: row_ready toggles 1,0,0,1 repeating -> every row delivered exactly once, data stable while stalled, total 9 handshakes.
REQ-045 Timeout: TIMEOUT=16, gen_done never asserted -> err=1, IDLE reached 16 cycles after GEN_WAIT entry; a following start clears err.
REQ-046 Zero seed and ignored start: seed_in=0 -> gen_seed=16'hACE1; a second start during STREAM -> no effect, single maze streamed.
REQ-047 Abort: abort at row_idx=4 -> row_valid=0 next cycle, maze_count unchanged, IDLE.
REQ-048 Wrap and reset: 256 completed mazes -> maze_count=0; rst pulse during GEN_WAIT -> all reset values immediately, no row_valid afterwards.
